// File: rtl/flit_link_sender.sv
// Drains a FIFO head/pull interface onto a credit-based link and tracks wormhole
// packet framing. Optional packet counter enabled by NOC_SENDER_STATS_EN.
module flit_link_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_head,
  input  logic [$clog2(DEPTH):0]   i_counter,
  output logic                     o_pull,
  output logic                     o_tx,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_eop,
  input  logic                     i_credit,
  output logic                     o_busy
`ifdef NOC_SENDER_STATS_EN
  ,
  output logic [15:0]              o_pkt_count
`endif
);

  typedef enum logic [1:0] {S_HDR, S_SIZE, S_PAY} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               tx_q, tx_d;
  logic               eop_q, eop_d;
  logic               load;
  logic               xfer;

  assign xfer = tx_q && i_credit;
  // Output register can accept a new flit when empty or being drained this cycle.
  assign load = (i_counter != '0) && (!tx_q || i_credit);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_HDR;
      remaining_q <= '0;
      data_q      <= '0;
      tx_q        <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      eop_q       <= eop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      case (state_q)
        S_HDR:   state_d = S_SIZE;
        S_SIZE:  state_d = (i_head == '0) ? S_HDR : S_PAY;
        S_PAY:   state_d = (remaining_q == WIDTH'(1)) ? S_HDR : S_PAY;
        default: state_d = S_HDR;
      endcase
    end
  end

  always_comb begin
    o_pull      = load;
    o_busy      = (state_q != S_HDR);
    tx_d        = tx_q;
    data_d      = data_q;
    eop_d       = eop_q;
    remaining_d = remaining_q;
    if (load) begin
      tx_d   = 1'b1;
      data_d = i_head;
      case (state_q)
        S_HDR: eop_d = 1'b0;
        S_SIZE: begin
          remaining_d = i_head;
          eop_d       = (i_head == '0);
        end
        S_PAY: begin
          // Only reached with remaining >= 1, so this never underflows.
          remaining_d = remaining_q - WIDTH'(1);
          eop_d       = (remaining_q == WIDTH'(1));
        end
        default: eop_d = 1'b0;
      endcase
    end else if (xfer) begin
      tx_d  = 1'b0;
      eop_d = 1'b0;
    end
  end

  assign o_tx   = tx_q;
  assign o_data = data_q;
  assign o_eop  = eop_q;

`ifdef NOC_SENDER_STATS_EN
  logic [15:0] pkt_count_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)             pkt_count_q <= '0;
    else if (xfer && eop_q) pkt_count_q <= pkt_count_q + 16'd1;
  end

  assign o_pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_flit_link_sender.sv
// Scoreboard bench for flit_link_sender: a FIFO model feeds the DUT and every
// link transfer is compared against the flit/eop pushed when stimulus was queued.
module tb_flit_link_sender;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic             eop;
    logic [WIDTH-1:0] data;
  } flit_t;

  logic                   i_clk;
  logic                   i_rst;
  logic [WIDTH-1:0]       i_head;
  logic [$clog2(DEPTH):0] i_counter;
  logic                   o_pull;
  logic                   o_tx;
  logic [WIDTH-1:0]       o_data;
  logic                   o_eop;
  logic                   i_credit;
  logic                   o_busy;
`ifdef NOC_SENDER_STATS_EN
  logic [15:0]            o_pkt_count;
`endif

  flit_link_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_head    (i_head),
    .i_counter (i_counter),
    .o_pull    (o_pull),
    .o_tx      (o_tx),
    .o_data    (o_data),
    .o_eop     (o_eop),
    .i_credit  (i_credit),
    .o_busy    (o_busy)
`ifdef NOC_SENDER_STATS_EN
    ,
    .o_pkt_count (o_pkt_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  flit_t fifo[$];
  flit_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    m_tx, m_busy, pend_load, pend_xfer;
  int    m_pkts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_flit(input logic [WIDTH-1:0] d, input bit last);
    flit_t f;
    f.data = d;
    f.eop  = last;
    fifo.push_back(f);
    sb.push_back(f);
  endtask

  task automatic drive_fifo();
    i_head    = (fifo.size() != 0) ? fifo[0].data : '0;
    i_counter = (fifo.size() > DEPTH) ? ($clog2(DEPTH)+1)'(DEPTH) : ($clog2(DEPTH)+1)'(fifo.size());
  endtask

  // One cycle: account for the edge just passed, drive inputs, check outputs.
  task automatic step(input bit cred);
    flit_t e;
    bit exp_load;
    @(negedge i_clk);
    if (pend_load) begin
      m_busy = !fifo[0].eop;
      void'(fifo.pop_front());
      m_tx = 1'b1;
    end else if (pend_xfer) begin
      m_tx = 1'b0;
    end
    i_credit = cred;
    drive_fifo();
    #1;
    chk("tx", 32'(o_tx), 32'(m_tx));
    chk("busy", 32'(o_busy), 32'(m_busy));
    if (!m_tx) chk("eop_idle", 32'(o_eop), 32'd0);
    exp_load = (fifo.size() != 0) && (!m_tx || cred);
    chk("pull", 32'(o_pull), 32'(exp_load));
    pend_xfer = m_tx && cred;
    if (pend_xfer) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(o_data), 32'(e.data));
        chk("eop", 32'(o_eop), 32'(e.eop));
        if (e.eop) m_pkts++;
      end
    end
    pend_load = exp_load;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_tx", 32'(o_tx), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_eop", 32'(o_eop), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    fifo.delete();
    sb.delete();
    drive_fifo();
    m_tx = 0; m_busy = 0; pend_load = 0; pend_xfer = 0; m_pkts = 0;
`ifdef NOC_SENDER_STATS_EN
    chk("rst_pkt_count", 32'(o_pkt_count), 32'd0);
`endif
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    bit cred_pat[10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    i_rst = 1'b0; i_credit = 1'b1; i_head = '0; i_counter = '0;
    m_tx = 0; m_busy = 0; pend_load = 0; pend_xfer = 0; m_pkts = 0;
    do_reset();

    // Idle with empty FIFO
    for (int k = 0; k < 10; k++) step(1'b1);

    // Back-to-back packet, credit always high
    push_flit(16'h0102, 0); push_flit(16'd3, 0);
    push_flit(16'h00AA, 0); push_flit(16'h00BB, 0); push_flit(16'h00CC, 1);
    run(8);
    chk("sb_empty_1", 32'(sb.size()), 32'd0);

    // Same packet with credit withheld while the size flit is on the link
    push_flit(16'h0102, 0); push_flit(16'd3, 0);
    push_flit(16'h00AA, 0); push_flit(16'h00BB, 0); push_flit(16'h00CC, 1);
    for (int k = 0; k < 10; k++) step(cred_pat[k]);
    run(3);
    chk("sb_empty_2", 32'(sb.size()), 32'd0);

    // Size-0 packet then size-1 packet
    push_flit(16'h0011, 0); push_flit(16'd0, 1);
    push_flit(16'h0022, 0); push_flit(16'd1, 0); push_flit(16'h0033, 1);
    run(8);
    chk("sb_empty_3", 32'(sb.size()), 32'd0);

    // FIFO drains mid-payload, then completes
    push_flit(16'h0044, 0); push_flit(16'd4, 0);
    push_flit(16'h0101, 0); push_flit(16'h0202, 0);
    run(7);
    chk("busy_stalled", 32'(o_busy), 32'd1);
    push_flit(16'h0303, 0); push_flit(16'h0404, 1);
    run(5);
    chk("sb_empty_4", 32'(sb.size()), 32'd0);

    // Random credit stress on a larger packet
    push_flit(16'h0055, 0); push_flit(16'd5, 0);
    for (int k = 0; k < 5; k++) push_flit(16'(16'h0500 + k), k == 4);
    for (int k = 0; k < 30; k++) step(1'($urandom_range(0, 1)));
    run(4);
    chk("sb_empty_5", 32'(sb.size()), 32'd0);

    // Reset mid-payload
    push_flit(16'h0066, 0); push_flit(16'd5, 0);
    for (int k = 0; k < 5; k++) push_flit(16'(16'h0600 + k), k == 4);
    run(4);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    chk("pre_rst_tx", 32'(o_tx), 32'd1);
    do_reset();

    // After reset: the next flit is a header; three complete packets
    push_flit(16'h0040, 0); push_flit(16'd0, 1);
    push_flit(16'h0041, 0); push_flit(16'd1, 0); push_flit(16'h0042, 1);
    push_flit(16'h0043, 0); push_flit(16'd2, 0); push_flit(16'h0044, 0); push_flit(16'h0045, 1);
    run(12);
    chk("sb_empty_6", 32'(sb.size()), 32'd0);
    chk("pkts_model", 32'(m_pkts), 32'd3);
`ifdef NOC_SENDER_STATS_EN
    chk("pkt_count", 32'(o_pkt_count), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flit_link_sender.md
Name: flit_link_sender

Overview:
- Output-side counterpart of the router input FIFO. Drains flits from an upstream FIFO's head/pull interface and drives them onto a credit-based inter-router link.
- Tracks wormhole packet framing: header flit, size flit, then exactly `size` payload flits.
- Marks the last flit of each packet on the link.
- Sits between a port FIFO and the physical link to the neighbouring router.

Parameters:
- WIDTH, `TAM_FLIT, flit width in bits.
- DEPTH, `TAM_BUFFER, depth of the feeding FIFO; sets the width of i_counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous active-low reset.
- i_head  input  WIDTH  head flit of the feeding FIFO; valid when i_counter != 0.
- i_counter  input  $clog2(DEPTH)+1  occupancy of the feeding FIFO.
- o_pull  output  1  combinational; pops the FIFO head at this clock edge.
- o_tx  output  1  link flit valid (registered).
- o_data  output  WIDTH  link flit (registered).
- o_eop  output  1  registered; qualifies o_data as the last flit of a packet.
- i_credit  input  1  the receiver accepts o_data this cycle.
- o_busy  output  1  high while a packet is partially sent, i.e. state != S_HDR.

Behaviour:
- Reset: asynchronous, active-low. Clears o_tx=0, o_data=0, o_eop=0, state=S_HDR, remaining=0, o_busy=0. Any flit already pulled or in the holding register is discarded. Reset may assert at any cycle, including mid-packet.
- Link transfer: a transfer occurs in a cycle where o_tx && i_credit.
  - While o_tx && !i_credit, o_data and o_eop hold stable.
- Load condition:
  - load = (i_counter != 0) && (!o_tx || i_credit).
  - o_pull = load, combinational, so the FIFO pops on the same edge.
- On load: o_data <= i_head, o_tx <= 1, o_eop <= computed last flag.
- Transfer with no load: o_tx <= 0 and o_eop <= 0; o_data keeps its value.
- Throughput and latency:
  - Sustains 1 flit/cycle when the FIFO is non-empty and i_credit is held high.
  - Latency is 1 cycle from pull to o_tx.
- States (advance only on load):
  - S_HDR: the loaded flit is the header; go to S_SIZE; eop=0.
  - S_SIZE: the loaded flit is the size.
    - remaining <= i_head, WIDTH bits, unsigned.
    - If i_head == 0: eop=1 and go to S_HDR.
    - Otherwise: eop=0 and go to S_PAY.
  - S_PAY: remaining <= remaining-1.
    - If remaining == 1: eop=1 and go to S_HDR.
    - Otherwise: eop=0 and stay in S_PAY.
- Boundary cases:
  - FIFO empty mid-packet: no pull; state and remaining hold; o_tx drops after the pending transfer. A bubble is legal.
  - i_credit low for N cycles: no pull after the register fills; no flit loss or duplication.
  - Size = 2^WIDTH-1: handled with no wrap; remaining never underflows.
  - A header cannot be loaded while in S_SIZE or S_PAY. Packets are never interleaved.
- o_busy: combinational, (state != S_HDR).

Optional Feature:
- Macro: NOC_SENDER_STATS_EN.
- Defined: adds output o_pkt_count, 16 bits.
  - Reset value 0.
  - Increments by 1 on each transfer with o_eop=1.
  - Wraps 0xFFFF to 0x0000.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: i_counter=0 for 10 cycles -> o_tx=0, o_pull=0, o_eop=0, o_busy=0.
- Packet hdr=0x0102, size=3, payload A,B,C preloaded, i_credit=1 -> o_pull high 5 consecutive cycles. o_data sequence 0x0102,3,A,B,C on consecutive cycles, starting 1 cycle after the first pull. o_eop=1 only with C.
- Same packet with i_credit low in cycles 2-4 -> o_data holds the size flit for 3 cycles, o_pull=0 meanwhile. Resumes with no loss or duplication; 5 transfers total.
- Size=0 packet followed by a size=1 packet back-to-back -> eop on the first size flit and on the single payload flit. o_busy low for exactly the one load edge between packets.
- FIFO drains mid-payload (size=4, only 2 payload flits available) -> o_tx drops and state stays S_PAY. The remaining 2 flits sent later complete the packet, with eop on the last.
- Reset asserted mid-payload -> o_tx=0 and o_busy=0 immediately (asynchronously). The next flit is treated as a header. With NOC_SENDER_STATS_EN, 3 completed packets -> o_pkt_count=3.
